// File: rtl/parity_word_checker.sv
`default_nettype none
// ============================================================================
// Module   : parity_word_checker
// Brief    : Parity check on a valid/ready word stream, with a one-stage output
//            register, error counting and lockout on a run of bad words.
// Revision : 1.0
// ============================================================================
module parity_word_checker #(
    parameter int N       = 8,
    parameter int ODD     = 0,
    parameter int CNT_W   = 8,
    parameter int LOCK_TH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_perr,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky,
    output logic             locked,
    input  logic             clr_err
);

    localparam int               c_cw         = $clog2(LOCK_TH + 1);
    localparam logic [c_cw-1:0]  c_lock_th    = c_cw'(LOCK_TH);
    localparam logic [c_cw-1:0]  c_consec_one = c_cw'(1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic             c_odd        = (ODD != 0);

    localparam logic [0:0] c_st_run    = 1'b0;
    localparam logic [0:0] c_st_locked = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [c_cw-1:0]  r_consec;
    logic [c_cw-1:0]  w_consec_nxt;
    logic             r_out_valid;
    logic [N-1:0]     r_out_data;
    logic             r_out_perr;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_err_sticky;
    logic             w_bad;
    logic             w_acc;
    logic             w_acc_bad;

    assign w_bad     = ((^in_data) ^ in_par) != c_odd;
    assign w_acc     = in_valid & in_ready;
    assign w_acc_bad = w_acc & w_bad;

    // A coincident clear still keeps the error that arrives with it.
    always_comb begin
        w_consec_nxt = r_consec;
        if (clr_err) begin
            w_consec_nxt = w_acc_bad ? c_consec_one : '0;
        end else if (w_acc) begin
            w_consec_nxt = w_bad ? (r_consec + 1'b1) : '0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run: begin
                if (w_acc_bad && (w_consec_nxt == c_lock_th)) begin
                    w_state_nxt = c_st_locked;
                end
            end
            c_st_locked: begin
                if (clr_err) begin
                    w_state_nxt = c_st_run;
                end
            end
            default: w_state_nxt = c_st_run;
        endcase
    end

    // Output logic; out_ready feeds in_ready combinationally so a full stage
    // can be refilled in the same cycle it drains.
    always_comb begin
        locked   = (r_state == c_st_locked);
        in_ready = (r_state == c_st_run) & (~r_out_valid | out_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_perr  <= 1'b0;
        end else if (w_acc) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
            r_out_perr  <= w_bad;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
            r_consec     <= '0;
        end else begin
            r_consec <= w_consec_nxt;
            if (clr_err) begin
                r_err_cnt    <= w_acc_bad ? c_cnt_one : '0;
                r_err_sticky <= w_acc_bad;
            end else begin
                if (w_acc_bad && (r_err_cnt != '1)) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                r_err_sticky <= r_err_sticky | w_acc_bad;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_perr   = r_out_perr;
    assign err_cnt    = r_err_cnt;
    assign err_sticky = r_err_sticky;

endmodule
`default_nettype wire
